id_ex_stage: RTL and testbench

Decode-to-execute pipeline stage of the pipelined RV32I core. It sits directly downstream of the register file. Each cycle it captures the two register-file read operands together with the decode-stage fields into the EX-stage register. It also detects load-use hazards against the instruction currently in EX and issues the stall requests. On a taken branch or jump it inserts a bubble. It keeps saturating stall and flush event counters for simulation.

---
 rtl/id_ex_stage.sv | 105 ++++++++++
 tb/tb_id_ex_stage.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register of the RV32I core: captures the decoded instruction for EX,
// detects load-use hazards against the EX instruction, and bubbles EX on hazard or flush.
module id_ex_stage #(
   parameter int CTRL_W = 8,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush_e,
   input  logic              valid_d,
   input  logic [4:0]        rs1_d,
   input  logic [4:0]        rs2_d,
   input  logic [4:0]        rd_d,
   input  logic              use_rs1_d,
   input  logic              use_rs2_d,
   input  logic [31:0]       rd1_d,
   input  logic [31:0]       rd2_d,
   input  logic [31:0]       imm_d,
   input  logic [31:0]       pc_d,
   input  logic [31:0]       pc_plus4_d,
   input  logic              reg_write_d,
   input  logic              mem_read_d,
   input  logic              mem_write_d,
   input  logic [CTRL_W-1:0] ctrl_d,
   output logic              valid_e,
   output logic              reg_write_e,
   output logic              mem_read_e,
   output logic              mem_write_e,
   output logic [4:0]        rs1_e,
   output logic [4:0]        rs2_e,
   output logic [4:0]        rd_e,
   output logic [31:0]       rd1_e,
   output logic [31:0]       rd2_e,
   output logic [31:0]       imm_e,
   output logic [31:0]       pc_e,
   output logic [31:0]       pc_plus4_e,
   output logic [CTRL_W-1:0] ctrl_e,
   output logic              stall_f,
   output logic              stall_d,
   output logic              flush_d,
   output logic [CNT_W-1:0]  sim_stall_cnt,
   output logic [CNT_W-1:0]  sim_flush_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic hazard;
   logic bubble;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + CNT_ONE;
   endfunction

   // A load in EX whose destination is read by the ID instruction must wait one cycle.
   always_comb begin
      hazard = valid_d && valid_e && mem_read_e && (rd_e != 5'd0) &&
               ((use_rs1_d && (rs1_d == rd_e)) || (use_rs2_d && (rs2_d == rd_e)));
   end

   // A flush already discards the ID instruction, so it takes priority over stalling it.
   assign stall_f = hazard & ~flush_e;
   assign stall_d = hazard & ~flush_e;
   assign flush_d = flush_e;
   assign bubble  = flush_e | hazard;

   // ---- ID -> EX boundary ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_e       <= 1'b0;
         reg_write_e   <= 1'b0;
         mem_read_e    <= 1'b0;
         mem_write_e   <= 1'b0;
         rs1_e         <= '0;
         rs2_e         <= '0;
         rd_e          <= '0;
         rd1_e         <= '0;
         rd2_e         <= '0;
         imm_e         <= '0;
         pc_e          <= '0;
         pc_plus4_e    <= '0;
         ctrl_e        <= '0;
         sim_stall_cnt <= '0;
         sim_flush_cnt <= '0;
      end else begin
         valid_e     <= valid_d & ~bubble;
         reg_write_e <= reg_write_d & ~bubble;
         mem_read_e  <= mem_read_d & ~bubble;
         mem_write_e <= mem_write_d & ~bubble;
         // Payload loads unconditionally; a bubble is marked invalid by the control bits alone.
         rs1_e       <= rs1_d;
         rs2_e       <= rs2_d;
         rd_e        <= rd_d;
         rd1_e       <= rd1_d;
         rd2_e       <= rd2_d;
         imm_e       <= imm_d;
         pc_e        <= pc_d;
         pc_plus4_e  <= pc_plus4_d;
         ctrl_e      <= ctrl_d;
         if (stall_d) sim_stall_cnt <= sat_inc(sim_stall_cnt);
         if (flush_e) sim_flush_cnt <= sat_inc(sim_flush_cnt);
      end
   end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: expected EX register contents are queued as each
// ID instruction is presented and compared one edge later.
module tb_id_ex_stage;

   localparam int CNT_W   = 4;
   localparam int CNT_SAT = 15;

   typedef struct packed {
      logic        valid;
      logic        rw;
      logic        mr;
      logic        mw;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] imm;
      logic [31:0] pc;
      logic [31:0] pcp4;
      logic [7:0]  ctrl;
   } e_t;

   typedef struct packed {
      e_t   f;
      logic use1;
      logic use2;
   } d_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic flush_e = 1'b0;
   d_t   d = '0;

   logic             valid_e, reg_write_e, mem_read_e, mem_write_e;
   logic [4:0]       rs1_e, rs2_e, rd_e;
   logic [31:0]      rd1_e, rd2_e, imm_e, pc_e, pc_plus4_e;
   logic [7:0]       ctrl_e;
   logic             stall_f, stall_d, flush_d;
   logic [CNT_W-1:0] sim_stall_cnt, sim_flush_cnt;

   int   checks = 0;
   int   fails  = 0;
   e_t   exp_q[$];
   e_t   m_e = '0;
   int   m_sc = 0;
   int   m_fc = 0;
   logic exp_stall;
   e_t   got_e, exp_e;

   id_ex_stage #(.CTRL_W(8), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .flush_e(flush_e), .valid_d(d.f.valid),
      .rs1_d(d.f.rs1), .rs2_d(d.f.rs2), .rd_d(d.f.rd),
      .use_rs1_d(d.use1), .use_rs2_d(d.use2),
      .rd1_d(d.f.rd1), .rd2_d(d.f.rd2), .imm_d(d.f.imm), .pc_d(d.f.pc), .pc_plus4_d(d.f.pcp4),
      .reg_write_d(d.f.rw), .mem_read_d(d.f.mr), .mem_write_d(d.f.mw), .ctrl_d(d.f.ctrl),
      .valid_e(valid_e), .reg_write_e(reg_write_e), .mem_read_e(mem_read_e), .mem_write_e(mem_write_e),
      .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
      .rd1_e(rd1_e), .rd2_e(rd2_e), .imm_e(imm_e), .pc_e(pc_e), .pc_plus4_e(pc_plus4_e),
      .ctrl_e(ctrl_e), .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d),
      .sim_stall_cnt(sim_stall_cnt), .sim_flush_cnt(sim_flush_cnt)
   );

   always #5 clk = ~clk;

   function automatic e_t sample_e();
      e_t s;
      s.valid = valid_e;  s.rw = reg_write_e;  s.mr = mem_read_e;  s.mw = mem_write_e;
      s.rs1 = rs1_e;  s.rs2 = rs2_e;  s.rd = rd_e;
      s.rd1 = rd1_e;  s.rd2 = rd2_e;  s.imm = imm_e;  s.pc = pc_e;  s.pcp4 = pc_plus4_e;
      s.ctrl = ctrl_e;
      return s;
   endfunction

   function automatic d_t mk(input logic mr, input logic mw, input logic rw,
                             input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                             input logic u1, input logic u2);
      d_t n;
      n.f.valid = 1'b1;  n.f.mr = mr;  n.f.mw = mw;  n.f.rw = rw;
      n.f.rs1 = rs1;  n.f.rs2 = rs2;  n.f.rd = rd;
      n.use1 = u1;  n.use2 = u2;
      n.f.rd1 = $urandom();  n.f.rd2 = $urandom();  n.f.imm = $urandom();
      n.f.pc = $urandom();  n.f.pcp4 = n.f.pc + 32'd4;
      n.f.ctrl = 8'($urandom());
      return n;
   endfunction

   // Present an ID instruction at the falling edge and queue what EX must hold after the next rise.
   task automatic drive(input d_t nd, input logic fl);
      logic hz;
      e_t   nx;
      @(negedge clk);
      d = nd;
      flush_e = fl;
      hz = nd.f.valid && m_e.valid && m_e.mr && (m_e.rd != 5'd0) &&
           ((nd.use1 && (nd.f.rs1 == m_e.rd)) || (nd.use2 && (nd.f.rs2 == m_e.rd)));
      exp_stall = hz && !fl;
      nx = nd.f;
      if (fl || hz) begin
         nx.valid = 1'b0;  nx.rw = 1'b0;  nx.mr = 1'b0;  nx.mw = 1'b0;
      end
      exp_q.push_back(nx);
      m_e = nx;
      if (exp_stall && m_sc < CNT_SAT) m_sc++;
      if (fl && m_fc < CNT_SAT) m_fc++;
      #1;
   endtask

   task automatic advance();
      @(posedge clk);
      #1;
      got_e = sample_e();
      if (exp_q.size() == 0) exp_e = 'x;
      else exp_e = exp_q.pop_front();
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if (sample_e() !== e_t'(0)) begin
         fails++; $display("FAIL reset_e_regs: got %h want 0", sample_e());
      end
      checks++;
      if (sim_stall_cnt !== 4'd0 || sim_flush_cnt !== 4'd0 || stall_d !== 1'b0) begin
         fails++; $display("FAIL reset_cnt: got stall_cnt=%0d flush_cnt=%0d stall_d=%b want 0 0 0",
                           sim_stall_cnt, sim_flush_cnt, stall_d);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_capture();
      for (int i = 0; i < 8; i++) begin
         d_t nd;
         nd = mk(1'($urandom()), 1'($urandom()), 1'($urandom()), 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom()), 1'($urandom()));
         nd.f.valid = (i == 3) ? 1'b0 : 1'($urandom());
         drive(nd, 1'b0);
         checks++;
         if (stall_d !== exp_stall || stall_f !== exp_stall) begin
            fails++; $display("FAIL capture_stall[%0d]: got %b/%b want %b", i, stall_f, stall_d, exp_stall);
         end
         advance();
         checks++;
         if (got_e !== exp_e) begin
            fails++; $display("FAIL capture_e[%0d]: got %h want %h", i, got_e, exp_e);
         end
      end
   endtask

   task automatic test_hazard_rs1();
      drive(mk(1'b1, 1'b0, 1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0), 1'b0);
      advance();
      checks++;
      if (got_e !== exp_e) begin
         fails++; $display("FAIL hazard_lw_e: got %h want %h", got_e, exp_e);
      end
      drive(mk(1'b0, 1'b0, 1'b1, 5'd5, 5'd7, 5'd6, 1'b1, 1'b1), 1'b0);
      checks++;
      if (stall_f !== 1'b1 || stall_d !== 1'b1 || flush_d !== 1'b0) begin
         fails++; $display("FAIL hazard_stall: got f=%b d=%b flush_d=%b want 1 1 0", stall_f, stall_d, flush_d);
      end
      advance();
      checks++;
      if (valid_e !== 1'b0 || reg_write_e !== 1'b0 || sim_stall_cnt !== 4'(m_sc)) begin
         fails++; $display("FAIL hazard_bubble: got valid=%b rw=%b cnt=%0d want 0 0 %0d",
                           valid_e, reg_write_e, sim_stall_cnt, m_sc);
      end
      checks++;
      if (got_e !== exp_e) begin
         fails++; $display("FAIL hazard_bubble_e: got %h want %h", got_e, exp_e);
      end
      drive(mk(1'b0, 1'b0, 1'b1, 5'd5, 5'd7, 5'd6, 1'b1, 1'b1), 1'b0);
      checks++;
      if (stall_d !== 1'b0) begin
         fails++; $display("FAIL hazard_release: got stall_d=%b want 0", stall_d);
      end
      advance();
      checks++;
      if (rd_e !== 5'd6 || valid_e !== 1'b1 || got_e !== exp_e) begin
         fails++; $display("FAIL hazard_proceed: got %h want %h", got_e, exp_e);
      end
   endtask

   task automatic test_no_hazard();
      // Load to x0 never blocks, even when ID reads x0.
      drive(mk(1'b1, 1'b0, 1'b1, 5'd2, 5'd0, 5'd0, 1'b1, 1'b0), 1'b0);
      advance();
      drive(mk(1'b0, 1'b0, 1'b1, 5'd3, 5'd0, 5'd8, 1'b0, 1'b1), 1'b0);
      checks++;
      if (stall_d !== 1'b0 || stall_f !== 1'b0) begin
         fails++; $display("FAIL x0_stall: got %b/%b want 0", stall_f, stall_d);
      end
      advance();
      checks++;
      if (got_e !== exp_e || valid_e !== 1'b1) begin
         fails++; $display("FAIL x0_capture: got %h want %h", got_e, exp_e);
      end
      // A non-load producer is forwarded in EX, not stalled.
      drive(mk(1'b0, 1'b0, 1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1), 1'b0);
      advance();
      drive(mk(1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd9, 1'b1, 1'b1), 1'b0);
      checks++;
      if (stall_d !== 1'b0) begin
         fails++; $display("FAIL nonload_stall: got %b want 0", stall_d);
      end
      advance();
      checks++;
      if (got_e !== exp_e) begin
         fails++; $display("FAIL nonload_capture: got %h want %h", got_e, exp_e);
      end
   endtask

   task automatic test_flush();
      drive(mk(1'b0, 1'b1, 1'b0, 5'd2, 5'd3, 5'd0, 1'b1, 1'b1), 1'b1);
      checks++;
      if (flush_d !== 1'b1 || stall_d !== 1'b0) begin
         fails++; $display("FAIL flush_d: got flush_d=%b stall_d=%b want 1 0", flush_d, stall_d);
      end
      advance();
      checks++;
      if (mem_write_e !== 1'b0 || valid_e !== 1'b0 || sim_flush_cnt !== 4'(m_fc) || got_e !== exp_e) begin
         fails++; $display("FAIL flush_bubble: got mw=%b valid=%b cnt=%0d want 0 0 %0d",
                           mem_write_e, valid_e, sim_flush_cnt, m_fc);
      end
   endtask

   task automatic test_flush_over_hazard();
      int sc_before;
      drive(mk(1'b1, 1'b0, 1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0), 1'b0);
      advance();
      sc_before = m_sc;
      drive(mk(1'b0, 1'b0, 1'b1, 5'd5, 5'd7, 5'd6, 1'b1, 1'b1), 1'b1);
      checks++;
      if (stall_d !== 1'b0 || stall_f !== 1'b0 || flush_d !== 1'b1) begin
         fails++; $display("FAIL flushwin_stall: got stall=%b/%b flush_d=%b want 0 0 1", stall_f, stall_d, flush_d);
      end
      advance();
      checks++;
      if (sim_stall_cnt !== 4'(sc_before) || sim_flush_cnt !== 4'(m_fc) || got_e !== exp_e) begin
         fails++; $display("FAIL flushwin_cnt: got stall_cnt=%0d flush_cnt=%0d want %0d %0d",
                           sim_stall_cnt, sim_flush_cnt, sc_before, m_fc);
      end
   endtask

   task automatic test_saturation();
      // lw x5,0(x5) repeated: every second cycle it hazards on its own predecessor.
      for (int i = 0; i < 44; i++) begin
         drive(mk(1'b1, 1'b0, 1'b1, 5'd5, 5'd0, 5'd5, 1'b1, 1'b0), 1'b0);
         advance();
         checks++;
         if (got_e !== exp_e || sim_stall_cnt !== 4'(m_sc)) begin
            fails++; $display("FAIL sat_step[%0d]: got %h cnt=%0d want %h cnt=%0d", i, got_e, sim_stall_cnt, exp_e, m_sc);
         end
      end
      checks++;
      if (sim_stall_cnt !== 4'd15) begin
         fails++; $display("FAIL sat_stick: got %0d want 15", sim_stall_cnt);
      end
   endtask

   task automatic test_async_reset();
      drive(mk(1'b1, 1'b1, 1'b1, 5'd4, 5'd4, 5'd4, 1'b1, 1'b1), 1'b0);
      advance();
      #2;
      rst = 1'b1;
      flush_e = 1'b1;
      #1;
      checks++;
      if (sample_e() !== e_t'(0) || sim_stall_cnt !== 4'd0 || sim_flush_cnt !== 4'd0) begin
         fails++; $display("FAIL async_reset: got %h cnt=%0d/%0d want 0", sample_e(), sim_stall_cnt, sim_flush_cnt);
      end
      checks++;
      if (stall_d !== 1'b0 || stall_f !== 1'b0 || flush_d !== 1'b1) begin
         fails++; $display("FAIL async_reset_comb: got stall=%b/%b flush_d=%b want 0 0 1", stall_f, stall_d, flush_d);
      end
      @(negedge clk);
      rst = 1'b0;
      flush_e = 1'b0;
      m_e = '0;
      m_sc = 0;
      m_fc = 0;
      exp_q.delete();
      drive(mk(1'b0, 1'b0, 1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1), 1'b0);
      advance();
      checks++;
      if (got_e !== exp_e || sim_flush_cnt !== 4'd0) begin
         fails++; $display("FAIL post_reset_capture: got %h want %h", got_e, exp_e);
      end
   endtask

   initial begin
      test_reset();
      test_capture();
      test_hazard_rs1();
      test_no_hazard();
      test_flush();
      test_flush_over_hazard();
      test_saturation();
      test_async_reset();
      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
